jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank_if.sv | 39 +++
 rtl/jk_reg_bank.sv | 112 +++++++++++
 tb/tb_jk_reg_bank.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if: bus bundle for the JK register bank.
// The master drives write/clear/read requests and the slave (the bank) returns
// read data and sweep status.
// Optional macro JK_REG_BANK_PARITY_EN adds the rd_parity return signal.
interface jk_reg_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  j;
    logic [WIDTH-1:0]  k;
    logic              clr_word;
    logic              clr_all;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;
`ifdef JK_REG_BANK_PARITY_EN
    logic              rd_parity;

    modport master (
        output we, addr, j, k, clr_word, clr_all, rd_addr,
        input  rd_data, busy, rd_parity
    );
    modport slave (
        input  we, addr, j, k, clr_word, clr_all, rd_addr,
        output rd_data, busy, rd_parity
    );
`else
    modport master (
        output we, addr, j, k, clr_word, clr_all, rd_addr,
        input  rd_data, busy
    );
    modport slave (
        input  we, addr, j, k, clr_word, clr_all, rd_addr,
        output rd_data, busy
    );
`endif
endinterface

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: DEPTH words of WIDTH JK flip-flops.
// Features:
//   - Per-word JK writes.
//   - Single-word clear.
//   - Bank-wide clear sweep, one word per cycle.
//   - Registered read with read-old semantics.
// preset is asynchronous and drives every word and rd_data to all-ones.
// Optional macro JK_REG_BANK_PARITY_EN adds a registered rd_parity output.
module jk_reg_bank #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             preset,
    jk_reg_bank_if.slave     bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                       r_state;
    logic [ADDR_W-1:0]            r_ptr;
    logic                         r_busy;
    logic [WIDTH-1:0]             r_mem [DEPTH];
    logic [WIDTH-1:0]             r_rd_data;
    logic                         w_wr_en;
    logic [DEPTH-1:0][WIDTH-1:0]  w_word_next;

    // Host writes and clears are only accepted while no sweep is running.
    assign w_wr_en = bus.we && (r_state == IDLE);

    // Next value of each word: the sweep clear wins, then clr_word, then JK.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        localparam logic [ADDR_W-1:0] LP_IDX = ADDR_W'(gi);
        logic [WIDTH-1:0] w_jk;

        // JK characteristic equation: q' = j&~q | ~k&q.
        assign w_jk = (bus.j & ~r_mem[gi]) | (~bus.k & r_mem[gi]);

        assign w_word_next[gi] =
            ((r_state == SWEEP) && (r_ptr == LP_IDX)) ? '0 :
            (w_wr_en && (bus.addr == LP_IDX))         ? (bus.clr_word ? '0 : w_jk) :
                                                        r_mem[gi];
    end

    // Sweep controller: IDLE waits for clr_all, SWEEP walks ptr across every word.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clr_all) begin
                        r_state <= SWEEP;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Word storage and registered read; the read samples the pre-update contents.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '1;
            end
            r_rd_data <= '1;
        end else begin
            r_rd_data <= r_mem[bus.rd_addr];
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_word_next[i];
            end
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.busy    = r_busy;

`ifdef JK_REG_BANK_PARITY_EN
    logic r_rd_parity;

    // Parity is taken from the same pre-update word as rd_data so the two stay aligned.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_rd_parity <= (WIDTH % 2 == 1);
        end else begin
            r_rd_parity <= ^r_mem[bus.rd_addr];
        end
    end

    assign bus.rd_parity = r_rd_parity;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed bench for jk_reg_bank.
// A per-word behavioural model (JK truth table, countdown of sweep cycles) is
// compared against the DUT every cycle, and literal expectations pin the model.
// Define JK_REG_BANK_PARITY_EN to also check rd_parity.
module tb_jk_reg_bank;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic clk;
    logic preset;
    int   checks   = 0;
    int   failures = 0;

    jk_reg_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    jk_reg_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .preset (preset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] exp_rd;
    int               sweep_left;
    int               sweep_idx;

    // Model reacts to the same edges as the DUT.
    always @(posedge clk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
            exp_rd     = 8'hFF;
            sweep_left = 0;
            sweep_idx  = 0;
        end else begin
            exp_rd = m_mem[bus.rd_addr];
            if (sweep_left > 0) begin
                m_mem[sweep_idx] = 8'h00;
                sweep_idx++;
                sweep_left--;
            end else begin
                if (bus.we) begin
                    if (bus.clr_word) begin
                        m_mem[bus.addr] = 8'h00;
                    end else begin
                        for (int b = 0; b < WIDTH; b++) begin
                            case ({bus.j[b], bus.k[b]})
                                2'b10:   m_mem[bus.addr][b] = 1'b1;
                                2'b01:   m_mem[bus.addr][b] = 1'b0;
                                2'b11:   m_mem[bus.addr][b] = ~m_mem[bus.addr][b];
                                default: ;
                            endcase
                        end
                    end
                end
                if (bus.clr_all) begin
                    sweep_left = DEPTH;
                    sweep_idx  = 0;
                end
            end
        end
    end

    // Every-cycle comparison, sampled shortly after the active edge.
    always @(posedge clk) begin
        #2;
        if (!preset) begin
            chk("cyc_rd_data", 32'(bus.rd_data), 32'(exp_rd));
            chk("cyc_busy", 32'(bus.busy), 32'(sweep_left > 0));
`ifdef JK_REG_BANK_PARITY_EN
            chk("cyc_rd_parity", 32'(bus.rd_parity), 32'(^exp_rd));
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs (called at a negedge) and wait for the next negedge.
    task automatic tick(input logic w, input logic [1:0] a, input logic [7:0] jj,
                        input logic [7:0] kk, input logic cw, input logic ca,
                        input logic [1:0] ra);
        bus.we       = w;
        bus.addr     = a;
        bus.j        = jj;
        bus.k        = kk;
        bus.clr_word = cw;
        bus.clr_all  = ca;
        bus.rd_addr  = ra;
        @(negedge clk);
    endtask

    initial begin
        int n;
        preset       = 1'b0;
        bus.we       = 1'b0;
        bus.addr     = '0;
        bus.j        = '0;
        bus.k        = '0;
        bus.clr_word = 1'b0;
        bus.clr_all  = 1'b0;
        bus.rd_addr  = '0;
        #1 preset = 1'b1;
        #2;
        chk("reset_rd_data", 32'(bus.rd_data), 32'hFF);
        chk("reset_busy", 32'(bus.busy), 32'h0);
`ifdef JK_REG_BANK_PARITY_EN
        chk("reset_parity", 32'(bus.rd_parity), 32'h0);
`endif
        repeat (2) @(negedge clk);
        preset = 1'b0;

        // All words read all-ones after preset.
        for (int a = 0; a < DEPTH; a++) begin
            tick(0, 0, 8'h00, 8'h00, 0, 0, 2'(a));
            chk("preset_word", 32'(bus.rd_data), 32'hFF);
            chk("preset_busy", 32'(bus.busy), 32'h0);
        end

        // JK set/reset, toggle, hold on word 1.
        tick(1, 1, 8'h0F, 8'hF0, 0, 0, 1);
        chk("jk_read_old", 32'(bus.rd_data), 32'hFF);
        tick(1, 1, 8'hFF, 8'hFF, 0, 0, 1);
        chk("jk_setreset", 32'(bus.rd_data), 32'h0F);
        tick(1, 1, 8'h00, 8'h00, 0, 0, 1);
        chk("jk_toggle", 32'(bus.rd_data), 32'hF0);
        tick(0, 0, 8'h00, 8'h00, 0, 0, 1);
        chk("jk_hold", 32'(bus.rd_data), 32'hF0);

        // clr_word overrides j; clr_word without we does nothing.
        tick(1, 2, 8'hFF, 8'h00, 1, 0, 2);
        tick(0, 3, 8'h00, 8'h00, 1, 0, 2);
        chk("clr_word2", 32'(bus.rd_data), 32'h00);
        tick(0, 0, 8'h00, 8'h00, 0, 0, 3);
        chk("clr_word_no_we_w3", 32'(bus.rd_data), 32'hFF);
        tick(0, 0, 8'h00, 8'h00, 0, 0, 0);
        chk("clr_word_w0", 32'(bus.rd_data), 32'hFF);

        // Same-cycle write and read of addr 0: old value, then new value.
        tick(1, 0, 8'h00, 8'hFF, 0, 0, 0);
        chk("rw_same_old", 32'(bus.rd_data), 32'hFF);
        tick(0, 0, 8'h00, 8'h00, 0, 0, 0);
        chk("rw_same_new", 32'(bus.rd_data), 32'h00);

        // Word 0 -> 8'h07, then 8'h03 (parity 1 then 0).
        tick(1, 0, 8'h07, 8'h00, 0, 0, 0);
        tick(1, 0, 8'h00, 8'h04, 0, 0, 0);
        chk("word_07", 32'(bus.rd_data), 32'h07);
`ifdef JK_REG_BANK_PARITY_EN
        chk("parity_07", 32'(bus.rd_parity), 32'h1);
`endif
        tick(0, 0, 8'h00, 8'h00, 0, 0, 0);
        chk("word_03", 32'(bus.rd_data), 32'h03);
`ifdef JK_REG_BANK_PARITY_EN
        chk("parity_03", 32'(bus.rd_parity), 32'h0);
`endif

        // One-cycle clr_all: busy for exactly DEPTH cycles, writes while busy dropped.
        tick(0, 0, 8'h00, 8'h00, 0, 1, 0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.busy) n++;
            tick(bus.busy, 2'(c), 8'hFF, 8'h00, 0, bus.busy, 2'(c));
        end
        chk("sweep_busy_cycles", 32'(n), 32'd4);
        for (int a = 0; a < DEPTH; a++) begin
            tick(0, 0, 8'h00, 8'h00, 0, 0, 2'(a));
            chk("sweep_cleared", 32'(bus.rd_data), 32'h00);
        end

        // Write and clr_all together: write lands first, then the sweep clears it.
        tick(1, 1, 8'hFF, 8'h00, 0, 1, 1);
        chk("wr_clr_all_busy", 32'(bus.busy), 32'h1);
        tick(0, 0, 8'h00, 8'h00, 0, 0, 1);
        chk("wr_clr_all_landed", 32'(bus.rd_data), 32'hFF);
        repeat (4) tick(0, 0, 8'h00, 8'h00, 0, 0, 1);
        chk("wr_clr_all_cleared", 32'(bus.rd_data), 32'h00);
        chk("wr_clr_all_idle", 32'(bus.busy), 32'h0);

        // preset at sweep cycle 2 aborts the sweep immediately.
        tick(0, 0, 8'h00, 8'h00, 0, 1, 0);
        tick(0, 0, 8'h00, 8'h00, 0, 0, 0);
        tick(0, 0, 8'h00, 8'h00, 0, 0, 0);
        #2 preset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_rd_data", 32'(bus.rd_data), 32'hFF);
        @(negedge clk);
        preset = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            tick(0, 0, 8'h00, 8'h00, 0, 0, 2'(a));
            chk("abort_word", 32'(bus.rd_data), 32'hFF);
            chk("abort_idle", 32'(bus.busy), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
